dmem_stall: RTL and testbench

Parametrised data memory for the pipelined MIPS with configurable access latency, per-byte write enables and a stall output for the hazard unit. It replaces the single-cycle data memory on the M-stage bus (address = ALU result, write data, memwrite). While an access is in flight it holds the whole pipeline frozen through `stallm`. It adds byte and halfword stores, plus a fixed wait-state count so slower memories can be modelled.

---
 rtl/mips_pkg.sv | 17 +
 rtl/bytemem_ram.sv | 38 +++
 rtl/dmem_stall.sv | 108 ++++++++++
 tb/tb_dmem_stall.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and limits for the MIPS data-memory path.
package mips_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_DONE = 2'd2
  } dmem_state_t;

  localparam int DMEM_LAT_MIN = 1;
  localparam int DMEM_LAT_MAX = 15;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/bytemem_ram.sv
// DEPTH x DATA_W single-port RAM with per-byte-lane write enables and a
// registered, enable-gated read port whose output register can be cleared.
module bytemem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic                  clk,
  input  logic                  q_rst,
  input  logic [DATA_W/8-1:0]   we,
  input  logic                  re,
  input  logic [AW-1:0]         idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (we[k]) begin
        mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Output register only changes on a committed load, so it holds between loads.
  always_ff @(posedge clk) begin
    if (q_rst) begin
      q <= '0;
    end else if (re) begin
      q <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_stall.sv
// M-stage data memory with fixed access latency; stallm freezes the pipeline
// while an access is in flight, and byte-lane enables allow partial stores.
module dmem_stall
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memreq,
  input  logic                  memwrite,
  input  logic [DATA_W/8-1:0]   byteen,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  stallm
);

  localparam int LANES = DATA_W / 8;
  localparam int BW    = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  generate
    if (LATENCY < DMEM_LAT_MIN || LATENCY > DMEM_LAT_MAX ||
        (DATA_W % 8) != 0 || DATA_W < 8 || !is_pow2(DEPTH) || DEPTH < 2) begin : g_param_check
      $error("dmem_stall: illegal DATA_W/DEPTH/LATENCY parameters");
    end
  endgenerate

  dmem_state_t state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        commit;
  logic        commit_ok;
  logic [LANES-1:0] lane_we;
  logic [AW-1:0]    word_idx;
  logic             unused_addr;

  assign word_idx    = addr[BW+AW-1:BW];
  assign unused_addr = ^addr;
  assign stallm      = memreq && (state_reg != DM_DONE);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    case (state_reg)
      DM_IDLE: begin
        if (memreq) begin
          if (LATENCY == 1) begin
            commit     = 1'b1;
            state_next = DM_DONE;
          end else begin
            cnt_next   = CNT_INIT;
            state_next = DM_WAIT;
          end
        end
      end
      DM_WAIT: begin
        // A request vanishing mid-wait means the hazard unit misbehaved; drop it.
        if (!memreq) begin
          state_next = DM_IDLE;
        end else if (cnt_reg == 4'd0) begin
          commit     = 1'b1;
          state_next = DM_DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DM_DONE: state_next = DM_IDLE;
      default: state_next = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= DM_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Reset on the commit edge must suppress both the write and the load.
  assign commit_ok = commit && !reset;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
    assign lane_we[gi] = commit_ok && memwrite && byteen[gi];
  end

  bytemem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .q_rst (reset),
    .we    (lane_we),
    .re    (commit_ok && !memwrite),
    .idx   (word_idx),
    .wdata (wdata),
    .q     (rdata)
  );

endmodule

// File: tb/tb_dmem_stall.sv
// Self-checking bench: three dmem_stall instances (LATENCY 1, 2, 15) driven
// one at a time and compared against a word-array reference model.
module tb_dmem_stall;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  memreq_v = 3'b000;
  logic        memwrite = 1'b0;
  logic [3:0]  byteen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rd0, rd1, rd2;
  logic        st0, st1, st2;

  int vectors = 0;
  int miscompares = 0;
  int lat_of [3] = '{1, 2, 15};

  logic [31:0] mdl [3][64];
  logic [31:0] mrd [3];

  always #5 clk = ~clk;

  dmem_stall #(.DATA_W(32), .DEPTH(64), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .memreq(memreq_v[0]), .memwrite(memwrite),
    .byteen(byteen), .addr(addr), .wdata(wdata), .rdata(rd0), .stallm(st0));
  dmem_stall #(.DATA_W(32), .DEPTH(64), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .memreq(memreq_v[1]), .memwrite(memwrite),
    .byteen(byteen), .addr(addr), .wdata(wdata), .rdata(rd1), .stallm(st1));
  dmem_stall #(.DATA_W(32), .DEPTH(64), .LATENCY(15)) u_lat15 (
    .clk(clk), .reset(reset), .memreq(memreq_v[2]), .memwrite(memwrite),
    .byteen(byteen), .addr(addr), .wdata(wdata), .rdata(rd2), .stallm(st2));

  function automatic logic get_st(input int d);
    case (d)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(input int d);
    case (d)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  // Called at a negedge with memreq already high; counts stall cycles and
  // samples rdata in the first non-stalled cycle; returns at a negedge.
  task automatic finish_access(input int d, output int stalls, output logic [31:0] rd);
    stalls = 0;
    rd = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!get_st(d)) begin
        rd = get_rd(d);
        break;
      end
      stalls++;
      @(negedge clk);
    end
    @(negedge clk);
    memreq_v[d] = 1'b0;
  endtask

  task automatic do_access(input int d, input bit wr, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int stalls, output logic [31:0] rd,
                           output logic [31:0] exp_rd);
    int idx;
    idx = int'((a >> 2) % 64);
    memwrite = wr;
    byteen = be;
    addr = a;
    wdata = wd;
    memreq_v[d] = 1'b1;
    finish_access(d, stalls, rd);
    if (wr) mdl[d][idx] = merge(mdl[d][idx], wd, be);
    else    mrd[d] = mdl[d][idx];
    exp_rd = mrd[d];
    $display("acc dut%0d %s addr=%h be=%h wdata=%h stalls=%0d rdata=%h",
             d, wr ? "st" : "ld", a, be, wd, stalls, rd);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    memreq_v = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      mrd[d] = 32'h0;
      vectors++;
      if (get_st(d) !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stallm dut%0d got=%b exp=0", d, get_st(d));
      end
      vectors++;
      if (get_rd(d) !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rdata dut%0d got=%h exp=0", d, get_rd(d));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    int s;
    logic [31:0] rd, ex;
    do_access(1, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF, s, rd, ex);
    vectors++;
    if (s !== 2) begin miscompares++; $display("FAIL basic_st_stalls got=%0d exp=2", s); end
    do_access(1, 1'b0, 4'h0, 32'h20, 32'h0, s, rd, ex);
    vectors++;
    if (s !== 2) begin miscompares++; $display("FAIL basic_ld_stalls got=%0d exp=2", s); end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL basic_ld_data got=%h exp=deadbeef", rd);
    end
  endtask

  task automatic test_byte_lanes;
    bit          wr_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  be_t [5] = '{4'hF, 4'h5, 4'h0, 4'h0, 4'h0};
    logic [31:0] wd_t [5] = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'hFFFFFFFF, 32'h0};
    int s;
    logic [31:0] rd, ex;
    for (int i = 0; i < 5; i++) begin
      do_access(1, wr_t[i], be_t[i], 32'h40, wd_t[i], s, rd, ex);
      vectors++;
      if (s !== 2) begin miscompares++; $display("FAIL lanes_stalls op%0d got=%0d exp=2", i, s); end
      vectors++;
      if (rd !== ex) begin miscompares++; $display("FAIL lanes_rdata op%0d got=%h exp=%h", i, rd, ex); end
    end
  endtask

  task automatic test_latency_extremes;
    int s;
    logic [31:0] rd, ex;
    for (int j = 0; j < 2; j++) begin
      int d;
      d = (j == 0) ? 0 : 2;
      for (int w = 0; w < 4; w++) begin
        do_access(d, 1'b1, 4'hF, 32'(w * 4), $urandom, s, rd, ex);
        vectors++;
        if (s !== lat_of[d]) begin
          miscompares++; $display("FAIL lat_st_stalls dut%0d got=%0d exp=%0d", d, s, lat_of[d]);
        end
      end
      for (int n = 0; n < 6; n++) begin
        do_access(d, 1'b0, 4'h0, 32'($urandom_range(0, 3) * 4), 32'h0, s, rd, ex);
        vectors++;
        if (s !== lat_of[d]) begin
          miscompares++; $display("FAIL lat_ld_stalls dut%0d got=%0d exp=%0d", d, s, lat_of[d]);
        end
        vectors++;
        if (rd !== ex) begin
          miscompares++; $display("FAIL lat_ld_data dut%0d got=%h exp=%h", d, rd, ex);
        end
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] a_t [4] = '{32'h100, 32'h000, 32'h003, 32'hFFFF_FF03};
    bit          w_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int s;
    logic [31:0] rd, ex;
    for (int i = 0; i < 4; i++) begin
      do_access(1, w_t[i], 4'hF, a_t[i], 32'hC0FFEE01, s, rd, ex);
      vectors++;
      if (rd !== ex) begin miscompares++; $display("FAIL wrap_rdata op%0d got=%h exp=%h", i, rd, ex); end
    end
    do_access(1, 1'b0, 4'h0, 32'h0000_00FC, 32'h0, s, rd, ex);
    do_access(1, 1'b1, 4'hF, 32'h0000_0104, 32'h5A5A0104, s, rd, ex);
    do_access(1, 1'b0, 4'h0, 32'h0000_0006, 32'h0, s, rd, ex);
    vectors++;
    if (rd !== 32'h5A5A0104) begin miscompares++; $display("FAIL wrap_alias got=%h exp=5a5a0104", rd); end
  endtask

  task automatic test_random;
    int s;
    logic [31:0] rd, ex, a;
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) do_access(d, 1'b1, 4'hF, 32'(w * 4), $urandom, s, rd, ex);
      for (int n = 0; n < 12; n++) begin
        a = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
        do_access(d, 1'($urandom), 4'($urandom), a, $urandom, s, rd, ex);
        vectors++;
        if (s !== lat_of[d]) begin
          miscompares++; $display("FAIL rand_stalls dut%0d got=%0d exp=%0d", d, s, lat_of[d]);
        end
        vectors++;
        if (rd !== ex) begin
          miscompares++; $display("FAIL rand_rdata dut%0d addr=%h got=%h exp=%h", d, a, rd, ex);
        end
      end
    end
  endtask

  task automatic test_reset_midwait;
    int s;
    logic [31:0] rd, ex;
    for (int j = 0; j < 2; j++) begin
      int d;
      d = j + 1;
      do_access(d, 1'b1, 4'hF, 32'h08, 32'h0BAD0008, s, rd, ex);
      memwrite = 1'b1; byteen = 4'hF; addr = 32'h08; wdata = 32'h55555555;
      memreq_v[d] = 1'b1;
      // dut1: reset lands on the commit edge; dut2: well inside the wait
      repeat ((d == 1) ? 1 : 6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      memreq_v = 3'b000;
      #1;
      for (int k = 0; k < 3; k++) begin
        mrd[k] = 32'h0;
        vectors++;
        if (get_st(k) !== 1'b0 || get_rd(k) !== 32'h0) begin
          miscompares++;
          $display("FAIL midwait_reset dut%0d stallm=%b rdata=%h exp 0/0", k, get_st(k), get_rd(k));
        end
      end
      @(negedge clk);
      do_access(d, 1'b0, 4'h0, 32'h08, 32'h0, s, rd, ex);
      vectors++;
      if (s !== lat_of[d]) begin miscompares++; $display("FAIL midwait_stalls dut%0d got=%0d", d, s); end
      vectors++;
      if (rd !== 32'h0BAD0008) begin
        miscompares++; $display("FAIL midwait_nowrite dut%0d got=%h exp=0bad0008", d, rd);
      end
    end
  endtask

  task automatic test_abort;
    int s;
    logic [31:0] rd, ex;
    do_access(2, 1'b1, 4'hF, 32'h0C, 32'h0000ABCD, s, rd, ex);
    memwrite = 1'b1; byteen = 4'hF; addr = 32'h0C; wdata = 32'hFFFF0000;
    memreq_v[2] = 1'b1;
    repeat (4) @(negedge clk);
    memreq_v[2] = 1'b0;
    #1;
    vectors++;
    if (st2 !== 1'b0) begin miscompares++; $display("FAIL abort_stallm got=%b exp=0", st2); end
    @(negedge clk);
    do_access(2, 1'b0, 4'h0, 32'h0C, 32'h0, s, rd, ex);
    vectors++;
    if (s !== 15) begin miscompares++; $display("FAIL abort_idle_stalls got=%0d exp=15", s); end
    vectors++;
    if (rd !== 32'h0000ABCD) begin miscompares++; $display("FAIL abort_nowrite got=%h exp=0000abcd", rd); end
  endtask

  task automatic test_reset_with_req;
    int s;
    logic [31:0] rd;
    reset = 1'b1;
    memwrite = 1'b0; byteen = 4'h0; addr = 32'h40; wdata = 32'h0;
    memreq_v[1] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) mrd[k] = 32'h0;
    finish_access(1, s, rd);
    mrd[1] = mdl[1][16];
    $display("acc dut1 ld addr=00000040 after reset stalls=%0d rdata=%h", s, rd);
    vectors++;
    if (s !== 2) begin miscompares++; $display("FAIL rst_req_stalls got=%0d exp=2", s); end
    vectors++;
    if (rd !== mrd[1]) begin miscompares++; $display("FAIL rst_req_rdata got=%h exp=%h", rd, mrd[1]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_byte_lanes;
    test_latency_extremes;
    test_wrap;
    test_random;
    test_reset_midwait;
    test_abort;
    test_reset_with_req;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
